// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared widths and lock-FSM state encoding for the UART TX arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BYTE_W   = 8;
    localparam int NTHREADS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Thread-side lock/write bus and serializer-side byte stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 256
);

    logic [NTHREADS-1:0] write_lock_req;
    logic [NTHREADS-1:0] write_lock_res;
    logic                write_ready;
    logic [BYTE_W-1:0]   data_in [NTHREADS];
    logic [NTHREADS-1:0] data_in_valid;
    logic [BYTE_W-1:0]   tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [$clog2(DEPTH):0] fifo_count;

    // Arbiter side
    modport slave (
        input  write_lock_req,
        input  data_in,
        input  data_in_valid,
        input  tx_ready,
        output write_lock_res,
        output write_ready,
        output tx_data,
        output tx_valid,
        output fifo_count
    );

    // Thread / serializer side
    modport master (
        output write_lock_req,
        output data_in,
        output data_in_valid,
        output tx_ready,
        input  write_lock_res,
        input  write_ready,
        input  tx_data,
        input  tx_valid,
        input  fifo_count
    );

endinterface : uart_tx_arbiter_if

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// Module   : byte_fifo
// Brief    : First-word fall-through byte FIFO; pushes while full are dropped.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [BYTE_W-1:0]       data_i,
    input  logic                    pop_i,
    output logic [BYTE_W-1:0]       data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule : byte_fifo

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Two-thread UART TX lock arbiter feeding a shared byte FIFO.
//            UART_TX_ARB_ROUND_ROBIN_EN selects round-robin tie-break
//            (default: fixed priority, thread 0 wins).
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    lock_state_e       state_q;
    lock_state_e       state_d;
    logic              tie_pick_1;
    logic              push;
    logic              pop;
    logic [BYTE_W-1:0] push_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    logic last_owner_q;

    // Reset value of 1 makes thread 0 the winner of the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner_q <= 1'b1;
        end else if (state_d == OWN0) begin
            last_owner_q <= 1'b0;
        end else if (state_d == OWN1) begin
            last_owner_q <= 1'b1;
        end
    end

    assign tie_pick_1 = ~last_owner_q;
`else
    assign tie_pick_1 = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.write_lock_req[0] && bus.write_lock_req[1]) begin
                    state_d = tie_pick_1 ? OWN1 : OWN0;
                end else if (bus.write_lock_req[0]) begin
                    state_d = OWN0;
                end else if (bus.write_lock_req[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0:    if (!bus.write_lock_req[0]) state_d = IDLE;
            OWN1:    if (!bus.write_lock_req[1]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.write_lock_res = {state_q == OWN1, state_q == OWN0};

    // Only the current owner's strobe reaches the FIFO.
    assign push = ((state_q == OWN0) && bus.data_in_valid[0]) ||
                  ((state_q == OWN1) && bus.data_in_valid[1]);
    assign push_data = (state_q == OWN1) ? bus.data_in[1] : bus.data_in[0];
    assign pop  = bus.tx_ready && !fifo_empty;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.write_ready = ~fifo_full;
    assign bus.tx_valid    = ~fifo_empty;
    assign bus.tx_data     = fifo_head;
    assign bus.fifo_count  = fifo_count;

endmodule : uart_tx_arbiter

`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning TX FIFO depth in bytes, power of two and at least 2.
REQ-002 SHALL have port clock, input, 1, system clock; reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port write_lock_req, input, [1:0], per-thread UART lock request.
REQ-004 SHALL have port write_lock_res, output, [1:0], per-thread lock grant, one-hot or zero.
REQ-005 SHALL have port write_ready, output, 1, high when FIFO not full.
REQ-006 SHALL have port data_in, input, 2 x [7:0] unpacked array, per-thread byte.
REQ-007 SHALL have port data_in_valid, input, [1:0], per-thread byte strobe.
REQ-008 SHALL have port tx_data, output, [7:0], FIFO head byte to the serializer.
REQ-009 SHALL have port tx_valid, output, 1, head byte valid.
REQ-010 SHALL have port tx_ready, input, 1, serializer accepts byte.
REQ-011 SHALL have port fifo_count, output, [$clog2(DEPTH):0], bytes currently stored.

Function
REQ-012 SHALL implement a lock FSM with states IDLE, OWN0 and OWN1, where write_lock_res[i] is high exactly in state OWNi (registered).
REQ-013 In IDLE with any request high, the FSM SHALL move to the selected owner's state on the next edge, so the grant appears one cycle after the request.
REQ-014 In OWNi, the FSM SHALL stay while write_lock_req[i] is high and return to IDLE on the edge after it drops, giving a mandatory one-cycle IDLE gap between owners.
REQ-015 The FSM SHALL not preempt an owner while it holds its lock; requests from the other thread wait.
REQ-016 A push SHALL occur iff in OWNi with data_in_valid[i] and write_ready; the pushed byte is data_in[i].
REQ-017 Strobes from a non-owner, or any strobe in IDLE, SHALL be dropped silently.
REQ-018 A push while full SHALL be dropped, leaving the FIFO contents and fifo_count unchanged; write_ready is 0 exactly when fifo_count == DEPTH.
REQ-019 The FIFO SHALL be first-word fall-through: tx_valid = (fifo_count != 0) and tx_data = the oldest byte.
REQ-020 A byte pushed at edge N SHALL be visible on tx_valid/tx_data in cycle N+1.
REQ-021 A pop SHALL occur on an edge where tx_valid and tx_ready are both high.
REQ-022 tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; when full, the push is still dropped per REQ-018 while the pop proceeds.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH or underflow.
REQ-025 tx_ready asserted while the FIFO is empty SHALL have no effect.

Reset
REQ-026 On reset, the FSM SHALL go to IDLE; write_lock_res=0, fifo_count=0, tx_valid=0, write_ready=1, and both pointers=0.
REQ-027 Reset mid-operation SHALL release any grant and discard all buffered bytes on that edge; FIFO storage contents are don't-care.

Configuration
REQ-028 Macro UART_TX_ARB_ROUND_ROBIN_EN defined SHALL select a round-robin policy: on a tie in IDLE, grant the thread that was not the last owner; after reset, thread 0 wins the first tie.
REQ-029 Macro UART_TX_ARB_ROUND_ROBIN_EN undefined SHALL select fixed priority: on a tie in IDLE, thread 0 always wins, and no last-owner register is instantiated.

Structure
REQ-030 The shared package uart_pkg SHALL hold: BYTE_W=8, NTHREADS=2, and the lock-FSM state enum (IDLE, OWN0, OWN1).
REQ-031 FIFO storage, pointers and count SHALL live in sub-module byte_fifo (parameter DEPTH; push, pop, full, empty, count); the arbiter FSM stays in uart_tx_arbiter.

Verification
REQ-032 Single-thread write: after reset, req[0]=1 -> res[0]=1 one cycle later; push 0x41, 0x42 with tx_ready=0 -> fifo_count=2, tx_data=0x41; then tx_ready=1 -> 0x41 then 0x42 drain, tx_valid=0, count=0.
REQ-033 Contention: req=2'b11 from IDLE -> res=2'b01; drop req[0] -> one IDLE cycle with res=0, then res=2'b10. With round-robin, a second tie after thread 1 releases -> grant goes to thread 0.
REQ-034 Fixed priority build: thread 1 owns, then releases while req=2'b11 twice in a row -> thread 0 is granted both times.
REQ-035 Full/wrap, DEPTH=4: push 0x10..0x13 -> write_ready=0; push 0x14 -> dropped; pop one, push 0x15 -> drain order 0x11, 0x12, 0x13, 0x15.
REQ-036 Non-owner and simultaneous cases: thread 1 strobes 0xFF while thread 0 owns -> not stored; full FIFO with push and pop in the same cycle -> count stays 3 (DEPTH=4), pushed byte lost.
REQ-037 Reset mid-stream: count=3 and res=2'b01, assert reset for 1 cycle -> count=0, tx_valid=0, res=0; req[0] still high -> regranted one cycle after reset drops.
